// File: rtl/addsub_mul_pkg.sv
// Shared constants and types for the add/subtract/multiply sequencer.
package addsub_mul_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Width of the multiply step counter, which must hold W-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/rca_addsub.sv
// W-bit ripple-carry adder with optional inversion of y; shared by add,
// subtract and the multiply accumulate step.
module rca_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         inv_y,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] y_eff;
    logic         carry;

    assign y_eff = inv_y ? ~y : y;

    // Ripple the carry from the LSB upward.
    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            s[i]  = x[i] ^ y_eff[i] ^ carry;
            carry = (x[i] & y_eff[i]) | (carry & (x[i] ^ y_eff[i]));
        end
    end

    assign cout = carry;
    // Signed overflow: both addends share a sign that the sum does not.
    assign ovf  = (x[W-1] == y_eff[W-1]) && (s[W-1] != x[W-1]);

endmodule

// File: rtl/addsub_mul_seq.sv
// Sequential arithmetic unit: add with carry-in, subtract with borrow-in and
// unsigned shift-add multiply, driven by a start/busy/done handshake.
module addsub_mul_seq
    import addsub_mul_pkg::*;
#(
    parameter int W      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [1:0]     MODE,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           A_m,
    input  logic           B_m,
    input  logic           C_we,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] Q,
    output logic           C_wy,
    output logic           V,
    output logic           ERR
);

    localparam int CW = cnt_width(W);

    state_t         state;
    state_t         state_nxt;

    // Captured operands; acc holds {partial product, multiplier} during a
    // multiply and simply carries operand b for add/sub.
    logic [W-1:0]   a_r;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [1:0]     mode_r;
    logic           cin_r;
    logic [CW-1:0]  cnt;

    logic           is_mul;
    logic           is_sub;
    logic           is_rsv;
    logic           last;

    logic [W-1:0]   add_x;
    logic [W-1:0]   add_y;
    logic           add_cin;
    logic           add_inv;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;

    assign is_mul = (mode_r == MODE_MUL) && MUL_EN;
    assign is_sub = (mode_r == MODE_SUB);
    assign is_rsv = (mode_r == MODE_RSV) || ((mode_r == MODE_MUL) && !MUL_EN);
    assign last   = !is_mul || (cnt == '0);
    assign BUSY   = (state == EXEC);

    // Steer the single adder: accumulate step for multiply, a +/- b otherwise.
    always_comb begin
        add_x   = a_r;
        add_y   = acc[W-1:0];
        add_cin = cin_r;
        add_inv = 1'b0;
        if (is_mul) begin
            add_x   = acc[2*W-1:W];
            add_y   = a_r;
            add_cin = 1'b0;
        end else if (is_sub) begin
            add_inv = 1'b1;
            add_cin = ~cin_r;
        end
    end

    rca_addsub #(.W(W)) u_rca (
        .x     (add_x),
        .y     (add_y),
        .cin   (add_cin),
        .inv_y (add_inv),
        .s     (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // One shift-add step: add multiplicand to the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    always_comb begin
        acc_nxt = {1'b0, acc[2*W-1:1]};
        if (acc[0]) begin
            acc_nxt = {cout, sum, acc[W-1:1]};
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept START only when idle, leave EXEC on the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = EXEC;
            EXEC:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at START and accumulator/counter stepping during multiply.
    always_ff @(posedge CLK) begin
        if (state == IDLE && START) begin
            a_r    <= A & {W{A_m}};
            acc    <= {{W{1'b0}}, B & {W{B_m}}};
            mode_r <= MODE;
            cin_r  <= C_we;
            cnt    <= CW'(W - 1);
        end else if (state == EXEC && is_mul) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
        end
    end

    // Result registers: updated only when an operation completes, held otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DONE <= 1'b0;
            Q    <= '0;
            C_wy <= 1'b0;
            V    <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == EXEC && last) begin
                DONE <= 1'b1;
                if (is_mul) begin
                    Q    <= acc_nxt;
                    C_wy <= 1'b0;
                    V    <= 1'b0;
                    ERR  <= 1'b0;
                end else if (is_rsv) begin
                    Q    <= '0;
                    C_wy <= 1'b0;
                    V    <= 1'b0;
                    ERR  <= 1'b1;
                end else begin
                    Q    <= {{W{1'b0}}, sum};
                    C_wy <= is_sub ? ~cout : cout;
                    V    <= ovf;
                    ERR  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_mul_seq.sv
// Directed bench for addsub_mul_seq at W=8 with hand-computed expectations.
module tb_addsub_mul_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  MODE;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        A_m;
    logic        B_m;
    logic        C_we;
    logic        BUSY;
    logic        DONE;
    logic [15:0] Q;
    logic        C_wy;
    logic        V;
    logic        ERR;

    int total = 0;
    int bad   = 0;

    addsub_mul_seq #(.W(8), .MUL_EN(1'b1)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .MODE  (MODE),
        .A     (A),
        .B     (B),
        .A_m   (A_m),
        .B_m   (B_m),
        .C_we  (C_we),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Q     (Q),
        .C_wy  (C_wy),
        .V     (V),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally pulse a stray START while busy, then
    // check latency (edges from the START edge to the edge sampling DONE),
    // busy length and results. Returns in the DONE cycle.
    task automatic do_op(input string tag, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic am, input logic bm,
                         input logic cwe, input bit inject, input logic [15:0] eq,
                         input logic ec, input logic ev, input logic eerr,
                         input int elat);
        int lat;
        int busy_n;
        MODE  = m;
        A     = a;
        B     = b;
        A_m   = am;
        B_m   = bm;
        C_we  = cwe;
        START = 1'b1;
        tick();
        START = 1'b0;
        A     = 8'hA5;
        B     = 8'h3C;
        MODE  = 2'b01;
        C_we  = ~cwe;
        A_m   = ~am;
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            if (BUSY) busy_n++;
            if (inject && n == 3) begin
                START = 1'b1;
                MODE  = 2'b00;
                A     = 8'h01;
                B     = 8'h01;
            end else if (inject && n == 4) begin
                START = 1'b0;
            end
            tick();
            if (DONE) begin
                lat = n + 1;
                break;
            end
        end
        START = 1'b0;
        chk({tag, "_lat"},  lat,    elat);
        chk({tag, "_busy"}, busy_n, elat - 1);
        chk({tag, "_busy_at_done"}, BUSY, 1'b0);
        chk({tag, "_q"},    Q,      eq);
        chk({tag, "_c"},    C_wy,   ec);
        chk({tag, "_v"},    V,      ev);
        chk({tag, "_err"},  ERR,    eerr);
    endtask

    initial begin
        int dones;
        RST   = 1'b1;
        START = 1'b0;
        MODE  = 2'b00;
        A     = 8'h00;
        B     = 8'h00;
        A_m   = 1'b1;
        B_m   = 1'b1;
        C_we  = 1'b0;
        repeat (3) tick();
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_q",    Q,    16'h0000);
        chk("rst_c",    C_wy, 1'b0);
        chk("rst_v",    V,    1'b0);
        chk("rst_err",  ERR,  1'b0);
        RST = 1'b0;
        tick();

        // add with carry-in
        do_op("add1", 2'b00, 8'hC8, 8'h64, 1'b1, 1'b1, 1'b1, 1'b0, 16'h002D, 1'b1, 1'b0, 1'b0, 2);
        tick();
        chk("hold_done", DONE, 1'b0);
        chk("hold_q",    Q,    16'h002D);
        chk("hold_c",    C_wy, 1'b1);

        // subtract cases
        do_op("sub1", 2'b01, 8'h50, 8'h70, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00E0, 1'b1, 1'b0, 1'b0, 2);
        tick();
        do_op("sub2", 2'b01, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h007F, 1'b0, 1'b1, 1'b0, 2);
        tick();
        do_op("sub3", 2'b01, 8'h10, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0, 2);
        tick();

        // multiply cases
        do_op("mul1", 2'b10, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0, 9);
        tick();
        do_op("mul0", 2'b10, 8'h00, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9);
        tick();
        do_op("mul2", 2'b10, 8'h0D, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 16'h008F, 1'b0, 1'b0, 1'b0, 9);
        tick();

        // masks
        do_op("mask", 2'b00, 8'h37, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, 2);
        tick();

        // reserved mode, held error, then cleared by a valid add
        do_op("rsv", 2'b11, 8'h55, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
        tick();
        chk("rsv_hold_err", ERR, 1'b1);
        do_op("clr", 2'b00, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 2);
        tick();

        // START while busy is ignored
        do_op("inj", 2'b10, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 16'h03A8, 1'b0, 1'b0, 1'b0, 9);
        tick();
        chk("inj_after_done", DONE, 1'b0);
        chk("inj_after_busy", BUSY, 1'b0);

        // back-to-back: second START issued in the DONE cycle
        do_op("b2b1", 2'b00, 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 2);
        do_op("b2b2", 2'b01, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0, 2);
        tick();

        // reset in the fourth cycle of a multiply aborts it
        MODE  = 2'b10;
        A     = 8'hFF;
        B     = 8'hFF;
        A_m   = 1'b1;
        B_m   = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        chk("abort_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_q",    Q,    16'h0000);
        chk("abort_c",    C_wy, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE) dones++;
            tick();
        end
        chk("abort_no_done", dones, 0);
        chk("abort_idle",    BUSY,  1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
